// File: rtl/sccb_target.sv
// sccb_target -- SCCB responder (camera side of the bus).
//
// Oversamples SIO_C / SIO_D on clk, detects start and stop conditions,
// decodes the device ID, sub-address and write data, and presents an 8-bit
// register port. Handles the 3-phase write, the 2-phase address-set write
// and the 2-phase read (target drives 8 data bits, master answers NA).
//
// Ports
//   clk            system clock (single domain)
//   rst            synchronous active-high reset
//   sccb_clk_in    SIO_C pin, asynchronous to clk
//   sccb_data_in   SIO_D pin, asynchronous to clk
//   sccb_data_out  value driven on SIO_D while sccb_data_en=1, else 1
//   sccb_data_en   1 = target drives SIO_D
//   reg_addr       latched sub-address
//   reg_wdata      write data, valid while reg_we=1
//   reg_we         one-cycle write strobe
//   reg_re         one-cycle read request for reg_addr
//   reg_rdata      read data, valid the cycle after reg_re
//   busy           1 from start detect until stop detect
module sccb_target #(
   parameter logic [6:0] DEV_ID = 7'h3C,
   parameter bit         ACK_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sccb_clk_in,
   input  logic       sccb_data_in,
   output logic       sccb_data_out,
   output logic       sccb_data_en,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_ID, S_ID_X, S_SUB, S_SUB_X,
      S_WDATA, S_WDATA_X, S_RDATA, S_RD_NA, S_IGNORE
   } state_t;

   // Index 0 = SIO_C, index 1 = SIO_D.
   logic [1:0] pin_in;
   logic [1:0] sync_bus;
   logic [1:0] hist_bus;

   assign pin_in = {sccb_data_in, sccb_clk_in};

   // Two-flop synchronizer plus one history flop per line. Reset to 1 so
   // an idle (pulled-up) bus produces no edges when reset is released.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         logic hist_reg;
         always_ff @(posedge clk) begin
            if (rst) begin
               meta_reg <= 1'b1;
               sync_reg <= 1'b1;
               hist_reg <= 1'b1;
            end else begin
               meta_reg <= pin_in[gi];
               sync_reg <= meta_reg;
               hist_reg <= sync_reg;
            end
         end
         assign sync_bus[gi] = sync_reg;
         assign hist_bus[gi] = hist_reg;
      end
   endgenerate

   logic scl, scl_d, sda, sda_d;
   logic scl_rise, scl_fall, start_det, stop_det;

   assign scl      = sync_bus[0];
   assign scl_d    = hist_bus[0];
   assign sda      = sync_bus[1];
   assign sda_d    = hist_bus[1];
   assign scl_rise = scl & ~scl_d;
   assign scl_fall = ~scl & scl_d;
   // SIO_C must be high on both samples so an SIO_D edge that coincides
   // with an SIO_C edge is not mistaken for a start/stop.
   assign start_det = scl & scl_d & sda_d & ~sda;
   assign stop_det  = scl & scl_d & ~sda_d & sda;

   state_t     state_reg, state_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [7:0] shift_reg, shift_next;
   logic [7:0] tx_reg, tx_next;
   logic [7:0] addr_reg, addr_next;
   logic [7:0] wdata_reg, wdata_next;
   logic       x_half_reg, x_half_next;   // byte-ending fall already seen
   logic       rw_reg, rw_next;
   logic       drv_en_reg, drv_en_next;
   logic       drv_bit_reg, drv_bit_next;
   logic       we_reg, we_next;
   logic       re_reg, re_next;
   logic       re_d_reg;
   logic       busy_reg, busy_next;
   logic [7:0] rx_byte;

   assign rx_byte = {shift_reg[6:0], sda};

   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      shift_next   = shift_reg;
      // Read data arrives the cycle after reg_re; load it into the shifter.
      tx_next      = re_d_reg ? reg_rdata : tx_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      x_half_next  = x_half_reg;
      rw_next      = rw_reg;
      drv_en_next  = drv_en_reg;
      drv_bit_next = drv_bit_reg;
      we_next      = 1'b0;
      re_next      = 1'b0;
      busy_next    = busy_reg;

      if (start_det) begin
         state_next   = S_ID;
         bit_cnt_next = 3'd7;
         x_half_next  = 1'b0;
         drv_en_next  = 1'b0;
         drv_bit_next = 1'b1;
         busy_next    = 1'b1;
      end else if (stop_det) begin
         state_next   = S_IDLE;
         x_half_next  = 1'b0;
         drv_en_next  = 1'b0;
         drv_bit_next = 1'b1;
         busy_next    = 1'b0;
      end else begin
         case (state_reg)
            S_ID, S_SUB, S_WDATA: begin
               if (scl_rise) begin
                  shift_next   = rx_byte;
                  bit_cnt_next = bit_cnt_reg - 3'd1;   // wraps to 7 for the next byte
                  if (bit_cnt_reg == 3'd0) begin
                     x_half_next = 1'b0;
                     if (state_reg == S_ID) begin
                        if (rx_byte[7:1] == DEV_ID) begin
                           state_next = S_ID_X;
                           rw_next    = rx_byte[0];
                           re_next    = rx_byte[0];
                        end else begin
                           state_next = S_IGNORE;
                        end
                     end else if (state_reg == S_SUB) begin
                        addr_next  = rx_byte;
                        state_next = S_SUB_X;
                     end else begin
                        wdata_next = rx_byte;
                        we_next    = 1'b1;
                        state_next = S_WDATA_X;
                     end
                  end
               end
            end
            S_ID_X, S_SUB_X, S_WDATA_X: begin
               if (scl_fall) begin
                  if (!x_half_reg) begin
                     // Fall that ends the byte: start of the X bit.
                     x_half_next = 1'b1;
                     if (ACK_EN) begin
                        drv_en_next  = 1'b1;
                        drv_bit_next = 1'b0;
                     end
                  end else begin
                     // Fall that ends the X bit.
                     x_half_next  = 1'b0;
                     bit_cnt_next = 3'd7;
                     drv_en_next  = 1'b0;
                     drv_bit_next = 1'b1;
                     if (state_reg == S_ID_X) begin
                        if (rw_reg) begin
                           state_next   = S_RDATA;
                           drv_en_next  = 1'b1;
                           drv_bit_next = tx_reg[7];
                           tx_next      = {tx_reg[6:0], 1'b1};
                        end else begin
                           state_next = S_SUB;
                        end
                     end else if (state_reg == S_SUB_X) begin
                        state_next = S_WDATA;
                     end else begin
                        state_next = S_IGNORE;
                     end
                  end
               end
            end
            S_RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_reg == 3'd0) begin
                     drv_en_next  = 1'b0;
                     drv_bit_next = 1'b1;
                     state_next   = S_RD_NA;
                  end else begin
                     drv_bit_next = tx_reg[7];
                     tx_next      = {tx_reg[6:0], 1'b1};
                     bit_cnt_next = bit_cnt_reg - 3'd1;
                  end
               end
            end
            S_RD_NA: begin
               if (scl_rise) begin
                  state_next = S_IGNORE;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         bit_cnt_reg <= 3'd0;
         shift_reg   <= 8'h00;
         tx_reg      <= 8'hFF;
         addr_reg    <= 8'h00;
         wdata_reg   <= 8'h00;
         x_half_reg  <= 1'b0;
         rw_reg      <= 1'b0;
         drv_en_reg  <= 1'b0;
         drv_bit_reg <= 1'b1;
         we_reg      <= 1'b0;
         re_reg      <= 1'b0;
         re_d_reg    <= 1'b0;
         busy_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         shift_reg   <= shift_next;
         tx_reg      <= tx_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         x_half_reg  <= x_half_next;
         rw_reg      <= rw_next;
         drv_en_reg  <= drv_en_next;
         drv_bit_reg <= drv_bit_next;
         we_reg      <= we_next;
         re_reg      <= re_next;
         re_d_reg    <= re_reg;
         busy_reg    <= busy_next;
      end
   end

   assign sccb_data_en  = drv_en_reg;
   assign sccb_data_out = drv_en_reg ? drv_bit_reg : 1'b1;
   assign reg_addr      = addr_reg;
   assign reg_wdata     = wdata_reg;
   assign reg_we        = we_reg;
   assign reg_re        = re_reg;
   assign busy          = busy_reg;

endmodule
